// File: rtl/muldiv_sequencer_pkg.sv
// Shared CPU defines for the mul/div sequencer.
// State encoding and default watchdog limit.
package muldiv_sequencer_pkg;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_M_RUN = 2'd1;
  localparam logic [1:0] ST_D_RUN = 2'd2;

  localparam int DEF_TIMEOUT = 64;

endpackage

// File: rtl/muldiv_watchdog.sv
// Run-cycle counter for the mul/div sequencer.
// Flags the last allowed run cycle.
module muldiv_watchdog #(
  parameter int TIMEOUT = 64
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  localparam int CW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;

  logic [CW-1:0] r_cnt;
  logic          w_at_lim;

  assign w_at_lim = (r_cnt == CW'(TIMEOUT - 1));
  assign expired  = w_at_lim;

  // saturate so a late enable never wraps back to zero
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_cnt <= '0;
    end else if (clear) begin
      r_cnt <= '0;
    end else if (enable && !w_at_lim) begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

endmodule

// File: rtl/muldiv_sequencer.sv
// Launches the iterative mul/div units and owns HI/LO.
// Flags divide-by-zero and unit timeouts.
module muldiv_sequencer
  import muldiv_sequencer_pkg::*;
#(
  parameter int WIDTH   = 32,
  parameter int TIMEOUT = DEF_TIMEOUT
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             mult_req,
  input  logic             div_req,
  input  logic [WIDTH-1:0] op_a,
  input  logic [WIDTH-1:0] op_b,
  input  logic             hi_rd_req,
  input  logic             lo_rd_req,
  output logic             mult_start,
  output logic             div_start,
  output logic [WIDTH-1:0] unit_a,
  output logic [WIDTH-1:0] unit_b,
  input  logic             mult_done,
  input  logic [WIDTH-1:0] mult_hi,
  input  logic [WIDTH-1:0] mult_lo,
  input  logic             div_done,
  input  logic [WIDTH-1:0] div_quot,
  input  logic [WIDTH-1:0] div_rem,
  output logic [WIDTH-1:0] hi_out,
  output logic [WIDTH-1:0] lo_out,
  output logic             busy,
  output logic             stall,
  output logic             done,
  output logic             div_zero,
  output logic             timeout
);

  logic [1:0]       r_state;
  logic [1:0]       w_state_nxt;
  logic [WIDTH-1:0] r_hi;
  logic [WIDTH-1:0] r_lo;
  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic             r_mstart;
  logic             r_dstart;
  logic             r_done;
  logic             r_dz;
  logic             r_to;

  logic w_idle;
  logic w_mrun;
  logic w_drun;
  logic w_run;
  logic w_bzero;
  logic w_acc_m;
  logic w_acc_d;
  logic w_dz;
  logic w_cmt_m;
  logic w_cmt_d;
  logic w_cmt;
  logic w_exp;
  logic w_to;

  assign w_idle  = (r_state == ST_IDLE);
  assign w_mrun  = (r_state == ST_M_RUN);
  assign w_drun  = (r_state == ST_D_RUN);
  assign w_run   = w_mrun | w_drun;
  assign w_bzero = (op_b == '0);

  // multiply wins when both requests arrive together
  assign w_acc_m = w_idle & mult_req;
  assign w_acc_d = w_idle & div_req & ~mult_req & ~w_bzero;
  assign w_dz    = w_idle & div_req & ~mult_req & w_bzero;

  assign w_cmt_m = w_mrun & mult_done;
  assign w_cmt_d = w_drun & div_done;
  assign w_cmt   = w_cmt_m | w_cmt_d;
  assign w_to    = w_run & w_exp & ~w_cmt;

  muldiv_watchdog #(
    .TIMEOUT (TIMEOUT)
  ) u_wdog (
    .clk     (clk),
    .reset   (reset),
    .clear   (w_acc_m | w_acc_d),
    .enable  (w_run),
    .expired (w_exp)
  );

  always_comb begin
    w_state_nxt = r_state;
    unique case (1'b1)
      w_acc_m:      w_state_nxt = ST_M_RUN;
      w_acc_d:      w_state_nxt = ST_D_RUN;
      w_cmt | w_to: w_state_nxt = ST_IDLE;
      default:      w_state_nxt = r_state;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state  <= ST_IDLE;
      r_hi     <= '0;
      r_lo     <= '0;
      r_a      <= '0;
      r_b      <= '0;
      r_mstart <= 1'b0;
      r_dstart <= 1'b0;
      r_done   <= 1'b0;
      r_dz     <= 1'b0;
      r_to     <= 1'b0;
    end else begin
      r_state  <= w_state_nxt;
      r_mstart <= w_acc_m;
      r_dstart <= w_acc_d;
      r_done   <= w_cmt;
      r_dz     <= w_dz;
      r_to     <= w_to;
      if (w_acc_m || w_acc_d) begin
        r_a <= op_a;
        r_b <= op_b;
      end
      if (w_cmt_m) begin
        r_hi <= mult_hi;
        r_lo <= mult_lo;
      end else if (w_cmt_d) begin
        r_hi <= div_rem;
        r_lo <= div_quot;
      end
    end
  end

  assign mult_start = r_mstart;
  assign div_start  = r_dstart;
  assign unit_a     = r_a;
  assign unit_b     = r_b;
  assign hi_out     = r_hi;
  assign lo_out     = r_lo;
  assign busy       = w_run;
  assign done       = r_done;
  assign div_zero   = r_dz;
  assign timeout    = r_to;
  assign stall      = w_run &
                      (mult_req | div_req |
                       hi_rd_req | lo_rd_req);

endmodule

// File: tb/tb_muldiv_sequencer.sv
// Directed bench for muldiv_sequencer.
// Hand-computed vectors, immediate assertions.
module tb_muldiv_sequencer;

  logic        clk = 1'b0;
  logic        reset;
  logic        mult_req, div_req;
  logic [31:0] op_a, op_b;
  logic        hi_rd_req, lo_rd_req;
  logic        mult_start, div_start;
  logic [31:0] unit_a, unit_b;
  logic        mult_done, div_done;
  logic [31:0] mult_hi, mult_lo;
  logic [31:0] div_quot, div_rem;
  logic [31:0] hi_out, lo_out;
  logic        busy, stall, done, div_zero, timeout;

  int n_chk  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  muldiv_sequencer #(
    .WIDTH   (32),
    .TIMEOUT (8)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .mult_req   (mult_req),
    .div_req    (div_req),
    .op_a       (op_a),
    .op_b       (op_b),
    .hi_rd_req  (hi_rd_req),
    .lo_rd_req  (lo_rd_req),
    .mult_start (mult_start),
    .div_start  (div_start),
    .unit_a     (unit_a),
    .unit_b     (unit_b),
    .mult_done  (mult_done),
    .mult_hi    (mult_hi),
    .mult_lo    (mult_lo),
    .div_done   (div_done),
    .div_quot   (div_quot),
    .div_rem    (div_rem),
    .hi_out     (hi_out),
    .lo_out     (lo_out),
    .busy       (busy),
    .stall      (stall),
    .done       (done),
    .div_zero   (div_zero),
    .timeout    (timeout)
  );

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h",
             tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset     = 1'b0;
    mult_req  = 1'b0;
    div_req   = 1'b0;
    op_a      = '0;
    op_b      = '0;
    hi_rd_req = 1'b0;
    lo_rd_req = 1'b0;
    mult_done = 1'b0;
    div_done  = 1'b0;
    mult_hi   = '0;
    mult_lo   = '0;
    div_quot  = '0;
    div_rem   = '0;
    tick();
    tick();
    chk("rst_busy", busy, 0);
    chk("rst_hi", hi_out, 0);
    chk("rst_lo", lo_out, 0);
    chk("rst_ua", unit_a, 0);
    chk("rst_pulses",
        {mult_start, div_start, done, div_zero, timeout}, 0);
    reset = 1'b1;
    tick();

    // multiply 7 * -3
    op_a = 32'd7;
    op_b = 32'hFFFF_FFFD;
    mult_req = 1'b1;
    tick();
    mult_req = 1'b0;
    chk("mul_start", mult_start, 1);
    chk("mul_dstart", div_start, 0);
    chk("mul_busy", busy, 1);
    chk("mul_ua", unit_a, 32'd7);
    chk("mul_ub", unit_b, 32'hFFFF_FFFD);
    tick();
    chk("mul_start_off", mult_start, 0);
    chk("mul_busy2", busy, 1);
    tick();
    tick();
    tick();
    tick();
    mult_done = 1'b1;
    mult_hi = 32'hFFFF_FFFF;
    mult_lo = 32'hFFFF_FFEB;
    chk("mul_no_early", done, 0);
    tick();
    mult_done = 1'b0;
    chk("mul_hi", hi_out, 32'hFFFF_FFFF);
    chk("mul_lo", lo_out, 32'hFFFF_FFEB);
    chk("mul_done", done, 1);
    chk("mul_idle", busy, 0);
    tick();
    chk("mul_done_off", done, 0);

    // divide 100 / 7 with MFHI waiting
    op_a = 32'd100;
    op_b = 32'd7;
    div_req = 1'b1;
    tick();
    div_req = 1'b0;
    hi_rd_req = 1'b1;
    #1;
    chk("div_start", div_start, 1);
    chk("div_mstart", mult_start, 0);
    chk("div_stall1", stall, 1);
    tick();
    chk("div_stall2", stall, 1);
    div_done = 1'b1;
    div_quot = 32'd14;
    div_rem  = 32'd2;
    tick();
    div_done = 1'b0;
    chk("div_lo", lo_out, 32'd14);
    chk("div_hi", hi_out, 32'd2);
    chk("div_done", done, 1);
    chk("div_stall_off", stall, 0);
    hi_rd_req = 1'b0;

    // divide by zero
    op_b = 32'd0;
    div_req = 1'b1;
    tick();
    div_req = 1'b0;
    chk("dz_pulse", div_zero, 1);
    chk("dz_nostart", div_start, 0);
    chk("dz_busy", busy, 0);
    chk("dz_hi", hi_out, 32'd2);
    chk("dz_lo", lo_out, 32'd14);
    tick();
    chk("dz_off", div_zero, 0);

    // timeout after 8 run cycles
    op_a = 32'd5;
    op_b = 32'd6;
    mult_req = 1'b1;
    tick();
    mult_req = 1'b0;
    for (int i = 0; i < 7; i++) tick();
    chk("to_busy8", busy, 1);
    chk("to_early", timeout, 0);
    tick();
    chk("to_pulse", timeout, 1);
    chk("to_busy", busy, 0);
    chk("to_hi", hi_out, 32'd2);
    chk("to_lo", lo_out, 32'd14);
    tick();
    chk("to_off", timeout, 0);

    // done on the limit cycle
    mult_req = 1'b1;
    tick();
    mult_req = 1'b0;
    for (int i = 0; i < 7; i++) tick();
    mult_done = 1'b1;
    mult_hi = 32'hAAAA_0001;
    mult_lo = 32'h5555_0002;
    tick();
    mult_done = 1'b0;
    chk("lim_done", done, 1);
    chk("lim_noto", timeout, 0);
    chk("lim_hi", hi_out, 32'hAAAA_0001);
    chk("lim_lo", lo_out, 32'h5555_0002);

    // arbitration, spurious done, back-to-back
    op_a = 32'd3;
    op_b = 32'd4;
    mult_req = 1'b1;
    div_req = 1'b1;
    tick();
    div_req = 1'b0;
    chk("arb_mstart", mult_start, 1);
    chk("arb_dstart", div_start, 0);
    div_done = 1'b1;
    div_quot = 32'd1;
    div_rem  = 32'd1;
    tick();
    div_done = 1'b0;
    chk("spur_done", done, 0);
    chk("spur_busy", busy, 1);
    chk("spur_lo", lo_out, 32'h5555_0002);
    chk("b2b_stall", stall, 1);
    mult_done = 1'b1;
    mult_hi = 32'h11;
    mult_lo = 32'h22;
    tick();
    mult_done = 1'b0;
    op_a = 32'd9;
    op_b = 32'd10;
    chk("b2b_done", done, 1);
    chk("b2b_hi", hi_out, 32'h11);
    chk("b2b_bubble", mult_start, 0);
    chk("b2b_nostall", stall, 0);
    tick();
    mult_req = 1'b0;
    chk("b2b_start", mult_start, 1);
    chk("b2b_ua", unit_a, 32'd9);

    // reset in run cycle 3
    tick();
    tick();
    chk("mid_busy", busy, 1);
    reset = 1'b0;
    #1;
    chk("rr_busy", busy, 0);
    chk("rr_hi", hi_out, 0);
    chk("rr_lo", lo_out, 0);
    chk("rr_ua", unit_a, 0);
    reset = 1'b1;
    mult_done = 1'b1;
    mult_hi = 32'h33;
    mult_lo = 32'h44;
    tick();
    mult_done = 1'b0;
    chk("rr_nodone", done, 0);
    chk("rr_hi2", hi_out, 0);
    chk("rr_busy2", busy, 0);

    $display("%0d/%0d checks passed",
             n_chk - n_fail, n_chk);
    $finish;
  end

endmodule
